conv_window_gen: RTL and testbench

- Upstream feeder of the 5x5 multiply-accumulate stage.
- Accepts a raster-order 8-bit pixel stream for one feature map, with one pixel per handshake.
- Buffers K-1 rows and emits every valid KxK window as one packed vector in the exact layout the MAC stage consumes.
- Provides valid/ready flow control on both sides, with backpressure propagated to the input.

---
 rtl/conv_window_gen_pkg.sv | 21 ++
 rtl/conv_line_buffer.sv | 23 ++
 rtl/conv_window_gen.sv | 186 ++++++++++++++++++
 tb/tb_conv_window_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the KxK window generator and the MAC stage that consumes
// its packed window: default sizes, FSM encoding and the element bit-offset helper.
package conv_window_gen_pkg;

   localparam int DATA_SIZE_DEF = 8;
   localparam int K_DEF         = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } cwg_state_e;

   // MSB of element (i,j); element (0,0) sits at the top of the packed vector.
   function automatic int win_elem_msb(input int i, input int j, input int k,
                                       input int data_size);
      return data_size * (k * k - (i * k + j)) - 1;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One row of delay: a DEPTH-deep, WIDTH-wide shift line advanced by shift_en_i.
// Contents are never cleared; the generator refills them before any window uses them.
module conv_line_buffer #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             shift_en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [DEPTH*WIDTH-1:0] sr_q;

   always_ff @(posedge clk_i) begin
      if (shift_en_i) begin
         sr_q <= {sr_q[DEPTH*WIDTH-WIDTH-1:0], din_i};
      end
   end

   assign dout_o = sr_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to packed KxK windows for the MAC stage, valid/ready both sides.
// CONV_WINDOW_ZERO_PAD_EN selects "same" zero padding instead of "valid" convolution.
//
// state | meaning
// IDLE  | waiting for start, no input accepted
// FILL  | loading rows 0..K-2 into the line buffers, no windows yet
// RUN   | every accepted pixel at r>=K-1, c>=K-1 yields a window
// DONE  | input closed, waiting for the last window handshake
module conv_window_gen
   import conv_window_gen_pkg::*;
#(
   parameter int IMG_W     = 32,
   parameter int IMG_H     = 32,
   parameter int K         = K_DEF,
   parameter int DATA_SIZE = DATA_SIZE_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [DATA_SIZE-1:0]      din,
   input  logic                      din_valid,
   output logic                      din_ready,
   output logic [DATA_SIZE*K*K-1:0]  win_data,
   output logic                      win_valid,
   input  logic                      win_ready,
   output logic                      busy,
   output logic                      frame_done
);

`ifdef CONV_WINDOW_ZERO_PAD_EN
   localparam int PAD = (K - 1) / 2;
   localparam int VW  = IMG_W + K - 1;
   localparam int VH  = IMG_H + K - 1;
`else
   localparam int VW  = IMG_W;
   localparam int VH  = IMG_H;
`endif
   localparam int CW = (VW > 1) ? $clog2(VW) : 1;
   localparam int RW = (VH > 1) ? $clog2(VH) : 1;
   localparam int WW = DATA_SIZE * K * K;

   localparam logic [CW-1:0] COL_LAST = CW'(VW - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(VH - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
   localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

   cwg_state_e           state_q, state_d;
   logic [RW-1:0]        row_q, row_d;
   logic [CW-1:0]        col_q, col_d;
   logic                 win_valid_q, win_valid_d;
   logic                 frame_done_q, frame_done_d;
   logic [WW-1:0]        win_q, win_d;

   logic                 hold, active, is_pad, advance, at_last, win_new;
   logic [DATA_SIZE-1:0] sample;
   logic [DATA_SIZE-1:0] lb_in  [K-1];
   logic [DATA_SIZE-1:0] lb_out [K-1];
   logic [DATA_SIZE-1:0] tap    [K];

   assign busy   = (state_q != ST_IDLE);
   assign hold   = win_valid_q & ~win_ready;
   assign active = busy & (state_q != ST_DONE) & ~hold;

`ifdef CONV_WINDOW_ZERO_PAD_EN
   // Border positions of the virtual grid advance on their own with a zero pixel.
   assign is_pad = (row_q < RW'(PAD)) | (row_q >= RW'(IMG_H + PAD)) |
                   (col_q < CW'(PAD)) | (col_q >= CW'(IMG_W + PAD));
`else
   assign is_pad = 1'b0;
`endif

   assign din_ready = active & ~is_pad;
   assign advance   = active & (is_pad | din_valid);
   assign sample    = is_pad ? '0 : din;
   assign at_last   = (row_q == ROW_LAST) & (col_q == COL_LAST);
   assign win_new   = advance & (row_q >= ROW_WIN) & (col_q >= COL_WIN);

   // tap[K-1] is the current row, tap[0] the oldest buffered row.
   assign tap[K-1]  = sample;
   assign lb_in[0]  = sample;

   for (genvar g = 0; g < K - 1; g++) begin : g_lb
      if (g > 0) begin : g_chain
         assign lb_in[g] = lb_out[g-1];
      end
      assign tap[K-2-g] = lb_out[g];

      conv_line_buffer #(
         .DEPTH (VW),
         .WIDTH (DATA_SIZE)
      ) u_lb (
         .clk_i      (clk),
         .shift_en_i (advance),
         .din_i      (lb_in[g]),
         .dout_o     (lb_out[g])
      );
   end

   // The window register is kept directly in the MAC packing; columns shift left.
   for (genvar gi = 0; gi < K; gi++) begin : g_row
      for (genvar gj = 0; gj < K; gj++) begin : g_col
         localparam int MSB = win_elem_msb(gi, gj, K, DATA_SIZE);
         if (gj == K - 1) begin : g_in
            assign win_d[MSB -: DATA_SIZE] = tap[gi];
         end else begin : g_shift
            localparam int MSB_R = win_elem_msb(gi, gj + 1, K, DATA_SIZE);
            assign win_d[MSB -: DATA_SIZE] = win_q[MSB_R -: DATA_SIZE];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      win_valid_d  = win_valid_q;
      frame_done_d = 1'b0;

      if (win_new) begin
         win_valid_d = 1'b1;
      end else if (win_ready) begin
         win_valid_d = 1'b0;
      end

      if (advance) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FILL;
               row_d   = '0;
               col_d   = '0;
            end
         end
         ST_FILL: begin
            if (advance && (row_q == ROW_WIN) && (col_q == '0)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (advance && at_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (win_valid_q && win_ready) begin
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         win_q        <= '0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         if (advance) begin
            win_q <= win_d;
         end
      end
   end

   assign win_data   = win_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: random/ramp frames against an array-based window model.
// Honours CONV_WINDOW_ZERO_PAD_EN the same way the design does.
`timescale 1ns/1ps
module tb_conv_window_gen;

   localparam int IMG_W  = 32;
   localparam int IMG_H  = 32;
   localparam int K      = 5;
   localparam int DS     = 8;
   localparam int WW     = DS * K * K;
   localparam int NPIX   = IMG_W * IMG_H;
`ifdef CONV_WINDOW_ZERO_PAD_EN
   localparam int PAD    = (K - 1) / 2;
   localparam int OW     = IMG_W;
   localparam int OH     = IMG_H;
`else
   localparam int PAD    = 0;
   localparam int OW     = IMG_W - K + 1;
   localparam int OH     = IMG_H - K + 1;
`endif
   localparam int NWIN   = OW * OH;
   localparam int BUDGET = 12000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DS-1:0] din;
   logic          din_valid;
   logic          din_ready;
   logic [WW-1:0] win_data;
   logic          win_valid;
   logic          win_ready;
   logic          busy;
   logic          frame_done;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] img [NPIX];

   conv_window_gen #(
      .IMG_W     (IMG_W),
      .IMG_H     (IMG_H),
      .K         (K),
      .DATA_SIZE (DS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .win_data   (win_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pix_at(input int r, input int c);
      if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W) return 8'h00;
      return img[r * IMG_W + c];
   endfunction

   // Window w in output raster order; elements appended top-left first so (0,0) ends at the MSB.
   function automatic logic [WW-1:0] exp_win(input int w);
      logic [WW-1:0] v;
      int r0, c0;
      r0 = w / OW - PAD;
      c0 = w % OW - PAD;
      v  = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            v = {v[WW-DS-1:0], pix_at(r0 + i, c0 + j)};
         end
      end
      return v;
   endfunction

   task automatic run_frame(input bit rnd_img, input int vprob, input int rprob,
                            input bit stall3, input bit poke, input int abort_at);
      int pix, wins, cyc, stall_left, hold_pix, done_cnt;
      bit fin, stalled;
      logic [WW-1:0] held;
      pix = 0; wins = 0; cyc = 0; stall_left = 0; hold_pix = 0; done_cnt = 0;
      fin = 1'b0; stalled = 1'b0; held = '0;

      for (int p = 0; p < NPIX; p++) begin
         img[p] = rnd_img ? 8'($urandom) : 8'(p & 'h7F);
      end

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      #1 chk("busy_after_start", WW'(busy), WW'(1));

      while (!fin && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         start     = poke && busy && (($urandom % 20) == 0);
         din_valid = (pix < NPIX) && (($urandom % 100) < vprob);
         din       = din_valid ? img[pix] : 8'($urandom);
         #1;
         if (stall3 && !stalled && win_valid && wins == 2) begin
            stalled    = 1'b1;
            stall_left = 10;
            held       = win_data;
            hold_pix   = pix;
         end
         win_ready = (stall_left > 0) ? 1'b0 : (($urandom % 100) < rprob);
         #1;
         if (stall_left > 0) begin
            chk("stall_data", win_data, held);
            chk("stall_valid", WW'(win_valid), WW'(1));
            chk("stall_din_ready", WW'(din_ready), WW'(0));
            stall_left--;
            if (stall_left == 0) chk("stall_no_pixel", WW'(pix), WW'(hold_pix));
         end
         if (frame_done) begin
            done_cnt++;
            chk("frame_done_after_last", WW'(wins), WW'(NWIN));
            fin = 1'b1;
         end
         if (win_valid && win_ready) begin
            if (wins < NWIN) begin
               chk("window", win_data, exp_win(wins));
               if (wins == 0 && !rnd_img) begin
                  chk("first_elem00", WW'(win_data[WW-1 -: DS]), WW'(0));
`ifdef CONV_WINDOW_ZERO_PAD_EN
                  chk("pad_first_elem22", WW'(win_data[DS*(K*K-12)-1 -: DS]), WW'(0));
                  chk("pad_first_elem44", WW'(win_data[DS-1:0]), WW'(8'h42));
`else
                  chk("first_elem44", WW'(win_data[DS-1:0]), WW'(img[4*IMG_W+4]));
`endif
               end
            end else begin
               chk("extra_window", WW'(wins), WW'(NWIN - 1));
            end
            wins++;
         end
         if (din_valid && din_ready) pix++;
         if (abort_at > 0 && pix == abort_at) begin
            din_valid = 1'b0;
            rst_n     = 1'b0;
            #1;
            chk("abort_win_valid", WW'(win_valid), WW'(0));
            chk("abort_win_data", win_data, WW'(0));
            chk("abort_busy", WW'(busy), WW'(0));
            chk("abort_din_ready", WW'(din_ready), WW'(0));
            return;
         end
      end

      din_valid = 1'b0;
      start     = 1'b0;
      chk("frame_finished", WW'(fin), WW'(1));
      chk("window_count", WW'(wins), WW'(NWIN));
      chk("pixel_count", WW'(pix), WW'(NPIX));
      @(negedge clk);
      #2;
      chk("frame_done_width", WW'(frame_done), WW'(0));
      chk("done_pulses", WW'(done_cnt), WW'(1));
      chk("idle_busy", WW'(busy), WW'(0));
      chk("idle_din_ready", WW'(din_ready), WW'(0));
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      win_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_win_valid", WW'(win_valid), WW'(0));
      chk("reset_din_ready", WW'(din_ready), WW'(0));
      chk("reset_busy", WW'(busy), WW'(0));
      chk("reset_frame_done", WW'(frame_done), WW'(0));
      chk("reset_win_data", win_data, WW'(0));
      rst_n = 1'b1;

      run_frame(1'b0, 100, 100, 1'b0, 1'b0, 0);   // ramp, continuous
      run_frame(1'b0, 100, 100, 1'b1, 1'b0, 0);   // ramp, 10-cycle hold on third window
      run_frame(1'b0,  50, 100, 1'b0, 1'b0, 0);   // ramp, gappy input
      run_frame(1'b1,  60,  70, 1'b0, 1'b1, 0);   // random data, start pokes while busy
      run_frame(1'b1, 100, 100, 1'b0, 1'b0, 500); // reset after 500 pixels
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(1'b0, 100, 100, 1'b0, 1'b0, 0);   // clean frame after the abort
      run_frame(1'b1,  80,  60, 1'b0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
